// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================
// muldiv_unit_if : operand/control bus of the HI/LO multiply-divide unit
// Rev 1.0
// ============================================================
interface muldiv_unit_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        start;
  logic [1:0]  op;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output SrcA, SrcB, start, op, hi_we, lo_we,
    input  hi, lo, busy, done
  );

  modport slave (
    input  SrcA, SrcB, start, op, hi_we, lo_we,
    output hi, lo, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================
// muldiv_unit : iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO
// Rev 1.0
// ============================================================
module muldiv_unit (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic        neg_q_q, neg_q_d;    // product/quotient sign
  logic        neg_r_q, neg_r_d;    // remainder sign
  logic        div0_q, div0_d;
  logic [31:0] orig_a_q, orig_a_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] rem_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign is_signed = ~bus.op[0];
  assign a_mag     = (is_signed && bus.SrcA[31]) ? (~bus.SrcA + 32'd1) : bus.SrcA;
  assign b_mag     = (is_signed && bus.SrcB[31]) ? (~bus.SrcB + 32'd1) : bus.SrcB;

  // Multiply: add into the upper half, then shift the whole product right.
  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};

  // Divide: partial remainder in the upper half, quotient bits enter at bit 0.
  assign div_rem   = {acc_q[63:32], a_q[31]};
  assign div_ge    = (div_rem >= {1'b0, b_q});
  assign div_diff  = div_rem[31:0] - b_q;
  assign rem_next  = div_ge ? div_diff : div_rem[31:0];

  assign prod_fix  = neg_q_q ? (~acc_q + 64'd1) : acc_q;
  assign quot_raw  = acc_q[31:0];
  assign rem_raw   = acc_q[63:32];
  assign quot_fix  = neg_q_q ? (~quot_raw + 32'd1) : quot_raw;
  assign rem_fix   = neg_r_q ? (~rem_raw + 32'd1) : rem_raw;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    orig_a_d = orig_a_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          neg_q_d  = is_signed & (bus.SrcA[31] ^ bus.SrcB[31]);
          neg_r_d  = is_signed & bus.SrcA[31];
          div0_d   = bus.op[1] & (bus.SrcB == 32'd0);
          orig_a_d = bus.SrcA;
          a_d      = a_mag;
          b_d      = b_mag;
          acc_d    = 64'd0;
          cnt_d    = 5'd0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          if (bus.hi_we) hi_d = bus.SrcA;
          if (bus.lo_we) lo_d = bus.SrcA;
        end
      end

      RUN: begin
        if (is_div_q) begin
          acc_d = {rem_next, acc_q[30:0], div_ge};
          a_d   = {a_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
          b_d   = {1'b0, b_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end

      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (div0_q) begin
          hi_d = orig_a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      orig_a_q <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      orig_a_q <= orig_a_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative HI/LO multiply/divide unit of the MIPS datapath, sitting directly downstream of the ALU source-B select stage. It consumes the register operand SrcA and the selected SrcB (register or extended immediate) for MULT/MULTU/DIV/DIVU, and produces the architectural HI/LO pair read by MFHI/MFLO. Each operation is multi-cycle, using a start/busy/done handshake with the control unit, which stalls the pipeline while `busy` is high.

## Interface
- No parameters; width fixed at 32 bits.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `SrcA` input 32: operand A (multiplicand / dividend).
- `SrcB` input 32: operand B (multiplier / divisor), from the source-B select stage.
- `start` input 1: launch operation; sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `hi_we` input 1: MTHI, writes `SrcA` into HI.
- `lo_we` input 1: MTLO, writes `SrcA` into LO.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when HI/LO have been updated by an operation.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE; `hi`=`lo`=0; `busy`=0; `done`=0; counter and working registers cleared. Applies mid-operation; the partial result is discarded.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE with `start`=1: latch `op`. Signed ops latch |SrcA|, |SrcB| and record the result signs: product sign = sign A XOR sign B; quotient sign = sign A XOR sign B; remainder sign = sign A. Unsigned ops latch raw values. Clear the 64-bit accumulator and the 5-bit counter. Go to RUN.
- RUN, multiply: one shift-add step per cycle, 32 steps, using an unsigned 32x32 -> 64 product.
- RUN, divide: one restoring step per cycle, 32 steps, using an unsigned 64-bit remainder/quotient shift register.
- RUN exits to FIX after the step with counter = 31.
- FIX: apply two's-complement negation per the recorded signs, then write HI/LO, pulse `done`, and return to IDLE.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU, SrcB=0): runs the full latency; LO = 32'hFFFFFFFF, HI = SrcA as latched (original, not magnitude).
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
- MULT 0x80000000 * 0x80000000: magnitude 0x80000000 is handled as unsigned; result HI=0x40000000, LO=0.
- MTHI/MTLO: in IDLE, `hi_we`/`lo_we` write `SrcA` at the edge. Both may be set together.
- `start` and `hi_we`/`lo_we` together in IDLE: `start` wins, and the writes are ignored.
- `start`, `hi_we`, `lo_we` while not in IDLE: ignored. HI/LO hold their old values until FIX.

## Timing
- Edge E0: `start` sampled in IDLE.
- `busy` is 1 from after E0 through E33.
- E1..E32: the 32 iteration steps.
- E33 (FIX): HI/LO updated and `done`=1 for the single cycle following E33; `busy`=0 from that cycle.
- Result latency: 33 cycles from the start edge, fixed for all ops including divide by zero.
- A new `start` may be accepted at E34, i.e. in the same cycle `done` is high, because state is IDLE.
- MTHI/MTLO latency: 1 edge.
- `hi`, `lo`, `busy`, `done` are all registered outputs with no combinational paths from inputs.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at E33: hi=0xFFFFFFFE, lo=0x00000001; done high exactly 1 cycle; busy high exactly 33 cycles.
- MULT -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0xF.
  - DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00000064.
- MTHI 0x1234 then MTLO 0x5678 in IDLE -> hi=0x1234, lo=0x5678 next edge.
  - Then start MULTU 2x3 with a second `start` and `hi_we` at E10 -> second start and write ignored; final hi=0, lo=6.
- Start MULT 5x5, assert `rst_n`=0 at E12 -> next cycle busy=0, done=0, hi=lo=0, state IDLE.
  - A start at the following edge completes normally with lo=25.
